// File: rtl/ahb_apb_pkg.sv
// Shared types and encodings for the parametrised AHB-Lite to APB3 bridge.
// Holds the bridge FSM state enum, AHB HTRANS encodings and HRESP values.
package ahb_apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LATCH  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } bridge_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam int SLOT_BITS = 4;

endpackage

// File: rtl/ahb_apb_timeout.sv
// ACCESS-phase wait counter: clears on entry to SETUP, counts PREADY-low cycles,
// and flags expiry on the last allowed cycle. TIMEOUT_CYCLES = 0 disables it.
module ahb_apb_timeout #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         logic unused_inputs;
         assign unused_inputs = ^{clk_i, rst_i, clr_i, en_i};
         assign expire_o      = 1'b0;
      end else begin : g_on
         localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

         logic [CW-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
               cnt_d = '0;
            end else if (en_i) begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign expire_o = en_i && (cnt_q == LAST);
      end
   endgenerate

endmodule

// File: rtl/ahb_apb_bridge_param.sv
// AHB-Lite slave to APB3 master bridge with generic widths and slot count,
// PREADY wait states, programmable access timeout and two-cycle ERROR responses.
module ahb_apb_bridge_param
   import ahb_apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 16,
   parameter int SLOT_SHIFT     = 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic                  HWRITE,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADYIN,
   output logic                  HREADYOUT,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HRESP,
   output logic [NUM_SLAVES-1:0] PSEL,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PWRITE,
   output logic                  PENABLE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR,
   output logic                  TIMEOUT_IRQ
);

   // Handshake: an AHB transfer is taken only when HSEL & HREADYIN & NONSEQ/SEQ
   // while the bridge shows HREADYOUT=1 (IDLE or ERR2); an APB access ends on the
   // first ACCESS cycle with PREADY=1, where PSLVERR decides OKAY versus ERROR.

   bridge_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [SLOT_BITS-1:0]  slot_q, slot_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
   logic                  irq_q, irq_d;

   logic                  xfer_valid;
   logic [SLOT_BITS-1:0]  haddr_slot;
   logic                  slot_oor;
   logic                  cnt_clr;
   logic                  cnt_en;
   logic                  expire;
   logic                  unused_inputs;

   assign unused_inputs = ^HSIZE;

   assign xfer_valid = HSEL && HREADYIN &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
   assign haddr_slot = HADDR[SLOT_SHIFT+SLOT_BITS-1:SLOT_SHIFT];
   assign slot_oor   = {1'b0, haddr_slot} >= 5'(NUM_SLAVES);
   assign cnt_en     = (state_q == ST_ACCESS) && !PREADY;

   ahb_apb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i    (HCLK),
      .rst_i    (HRESET),
      .clr_i    (cnt_clr),
      .en_i     (cnt_en),
      .expire_o (expire)
   );

   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      slot_d   = slot_q;
      pwdata_d = pwdata_q;
      hrdata_d = hrdata_q;
      irq_d    = 1'b0;
      cnt_clr  = 1'b0;
      case (state_q)
         ST_IDLE, ST_ERR2: begin
            state_d = ST_IDLE;
            if (xfer_valid) begin
               paddr_d  = HADDR;
               pwrite_d = HWRITE;
               slot_d   = haddr_slot;
               if (slot_oor) begin
                  state_d = ST_ERR1;
               end else if (HWRITE) begin
                  state_d = ST_LATCH;
               end else begin
                  state_d = ST_SETUP;
                  cnt_clr = 1'b1;
               end
            end
         end
         ST_LATCH: begin
            pwdata_d = HWDATA;
            state_d  = ST_SETUP;
            cnt_clr  = 1'b1;
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // PREADY wins over a timeout landing in the same cycle.
            if (PREADY) begin
               if (PSLVERR) begin
                  state_d = ST_ERR1;
               end else begin
                  state_d = ST_IDLE;
                  if (!pwrite_q) begin
                     hrdata_d = PRDATA;
                  end
               end
            end else if (expire) begin
               state_d = ST_ERR1;
               irq_d   = 1'b1;
            end
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q  <= ST_IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         slot_q   <= '0;
         pwdata_q <= '0;
         hrdata_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         slot_q   <= slot_d;
         pwdata_q <= pwdata_d;
         hrdata_q <= hrdata_d;
         irq_q    <= irq_d;
      end
   end

   // IRQ is registered, so it rises in the ERR1 cycle that follows the abort.
   assign TIMEOUT_IRQ = irq_q;
   assign PADDR       = paddr_q;
   assign PWRITE      = pwrite_q;
   assign PWDATA      = pwdata_q;
   assign HRDATA      = hrdata_q;
   assign PENABLE     = (state_q == ST_ACCESS);
   assign HREADYOUT   = (state_q == ST_IDLE) || (state_q == ST_ERR2);
   assign HRESP       = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR
                                                                         : HRESP_OKAY;

   always_comb begin
      PSEL = '0;
      if ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            PSEL[i] = (slot_q == 4'(i));
         end
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// Directed bench for ahb_apb_bridge_param: three instances share one stimulus
// (defaults, 4 slots with 8-cycle timeout, timeout disabled).
module tb_ahb_apb_bridge_param;
   import ahb_apb_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        HSEL, HWRITE, HREADYIN, PREADY, PSLVERR;
   logic [31:0] HADDR, HWDATA, PRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;

   logic        a_hready, a_hresp, a_penable, a_pwrite, a_irq;
   logic [31:0] a_hrdata, a_paddr, a_pwdata;
   logic [15:0] a_psel;

   logic        b_hready, b_hresp, b_penable, b_irq, unused_b_pwrite;
   logic [31:0] unused_b_hrdata, unused_b_paddr, unused_b_pwdata;
   logic [3:0]  b_psel;

   logic        c_hready, c_hresp, c_penable, unused_c_pwrite, unused_c_irq;
   logic [31:0] c_hrdata, unused_c_paddr, unused_c_pwdata;
   logic [15:0] c_psel;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   always #5 HCLK = ~HCLK;

   ahb_apb_bridge_param u_dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
      .HREADYOUT(a_hready), .HRDATA(a_hrdata), .HRESP(a_hresp), .PSEL(a_psel),
      .PADDR(a_paddr), .PWRITE(a_pwrite), .PENABLE(a_penable), .PWDATA(a_pwdata),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .TIMEOUT_IRQ(a_irq)
   );

   ahb_apb_bridge_param #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(8)) u_small (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
      .HREADYOUT(b_hready), .HRDATA(unused_b_hrdata), .HRESP(b_hresp), .PSEL(b_psel),
      .PADDR(unused_b_paddr), .PWRITE(unused_b_pwrite), .PENABLE(b_penable),
      .PWDATA(unused_b_pwdata), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .TIMEOUT_IRQ(b_irq)
   );

   ahb_apb_bridge_param #(.TIMEOUT_CYCLES(0)) u_nto (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
      .HREADYOUT(c_hready), .HRDATA(c_hrdata), .HRESP(c_hresp), .PSEL(c_psel),
      .PADDR(unused_c_paddr), .PWRITE(unused_c_pwrite), .PENABLE(c_penable),
      .PWDATA(unused_c_pwdata), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .TIMEOUT_IRQ(unused_c_irq)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic addr_phase(input logic [31:0] addr, input logic wr);
      HSEL   = 1'b1;
      HTRANS = HTRANS_NONSEQ;
      HADDR  = addr;
      HWRITE = wr;
      cyc();
      HSEL   = 1'b0;
      HTRANS = HTRANS_IDLE;
   endtask

   initial begin
      int c_wait;
      int a_irq_cnt;
      logic [3:0] b_psel_seen;
      logic [31:0] oor_addr [2];

      HRESET = 1'b1; HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = '0; HWRITE = 1'b0;
      HSIZE = 3'b010; HWDATA = '0; HREADYIN = 1'b1; PRDATA = '0; PREADY = 1'b1;
      PSLVERR = 1'b0;
      repeat (2) @(posedge HCLK);
      #1 HRESET = 1'b0;

      // reset state
      check_eq("rst_hready", a_hready, 1);
      check_eq("rst_hresp", a_hresp, 0);
      check_eq("rst_psel", a_psel, 0);
      check_eq("rst_penable", a_penable, 0);
      check_eq("rst_paddr", a_paddr, 0);
      check_eq("rst_pwdata", a_pwdata, 0);
      check_eq("rst_hrdata", a_hrdata, 0);
      check_eq("rst_irq", a_irq, 0);

      // BUSY is not a transfer
      HSEL = 1'b1; HTRANS = HTRANS_BUSY; HADDR = 32'h0000_0300;
      cyc();
      HSEL = 1'b0; HTRANS = HTRANS_IDLE;
      check_eq("busy_psel", a_psel, 0);
      check_eq("busy_hready", a_hready, 1);

      // write slot 3, zero-wait: LATCH, SETUP, ACCESS, completion on cycle 4
      addr_phase(32'h0000_0304, 1'b1);
      check_eq("wr_latch_hready", a_hready, 0);
      HWDATA = 32'hDEAD_BEEF;
      cyc();
      check_eq("wr_setup_psel", a_psel, 16'h0008);
      check_eq("wr_setup_psel_4slot", b_psel, 4'b1000);
      check_eq("wr_setup_penable", a_penable, 0);
      check_eq("wr_pwdata", a_pwdata, 32'hDEAD_BEEF);
      check_eq("wr_paddr", a_paddr, 32'h0000_0304);
      check_eq("wr_pwrite", a_pwrite, 1);
      cyc();
      check_eq("wr_access_psel", a_psel, 16'h0008);
      check_eq("wr_access_penable", a_penable, 1);
      check_eq("wr_access_hready", a_hready, 0);
      cyc();
      check_eq("wr_done_hready", a_hready, 1);
      check_eq("wr_done_hresp", a_hresp, 0);
      check_eq("wr_done_psel", a_psel, 0);
      check_eq("wr_paddr_hold", a_paddr, 32'h0000_0304);
      idle_cycles(3);

      // read slot 5 with three wait states
      PREADY = 1'b0;
      addr_phase(32'h0000_0500, 1'b0);
      check_eq("rd5_setup_psel", a_psel, 16'h0020);
      check_eq("rd5_pwrite", a_pwrite, 0);
      c_wait = 0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         if (a_penable && !a_hready) c_wait++;
      end
      PREADY = 1'b1; PRDATA = 32'h1234_5678;
      cyc();
      check_eq("rd5_penable_cycles", c_wait, 4);
      check_eq("rd5_hready", a_hready, 1);
      check_eq("rd5_hrdata", a_hrdata, 32'h1234_5678);
      check_eq("rd5_hresp", a_hresp, 0);
      idle_cycles(3);

      // slave error on slot 2
      PSLVERR = 1'b1; PRDATA = 32'hBAD0_BAD0;
      addr_phase(32'h0000_0200, 1'b0);
      cyc();
      cyc();
      check_eq("slverr_err1_hready", a_hready, 0);
      check_eq("slverr_err1_hresp", a_hresp, 1);
      check_eq("slverr_err1_psel", a_psel, 0);
      check_eq("slverr_err1_penable", a_penable, 0);
      cyc();
      check_eq("slverr_err2_hready", a_hready, 1);
      check_eq("slverr_err2_hresp", a_hresp, 1);
      cyc();
      check_eq("slverr_idle_hresp", a_hresp, 0);
      check_eq("slverr_hrdata_hold", a_hrdata, 32'h1234_5678);
      PSLVERR = 1'b0;
      idle_cycles(3);

      // out-of-range slots on the 4-slot instance: boundary 4 and slot 9
      oor_addr[0] = 32'h0000_0400;
      oor_addr[1] = 32'h0000_0900;
      for (int j = 0; j < 2; j++) begin
         b_psel_seen = '0;
         addr_phase(oor_addr[j], 1'b0);
         b_psel_seen |= b_psel;
         check_eq("oor_err1_hready", b_hready, 0);
         check_eq("oor_err1_hresp", b_hresp, 1);
         cyc();
         b_psel_seen |= b_psel;
         check_eq("oor_err2_hready", b_hready, 1);
         check_eq("oor_err2_hresp", b_hresp, 1);
         cyc();
         b_psel_seen |= b_psel;
         check_eq("oor_idle_hresp", b_hresp, 0);
         check_eq("oor_psel_never", b_psel_seen, 0);
         idle_cycles(3);
      end

      // timeout after 8 ACCESS cycles; the no-timeout instance keeps waiting
      PREADY = 1'b0;
      addr_phase(32'h0000_0100, 1'b0);
      cyc();
      for (int k = 1; k <= 8; k++) begin
         check_eq("to_waiting", b_penable && !b_irq, 1);
         cyc();
      end
      check_eq("to_irq", b_irq, 1);
      check_eq("to_psel_drop", b_psel, 0);
      check_eq("to_penable_drop", b_penable, 0);
      check_eq("to_err1_hresp", b_hresp, 1);
      check_eq("to_err1_hready", b_hready, 0);
      cyc();
      check_eq("to_irq_pulse", b_irq, 0);
      check_eq("to_err2_hresp", b_hresp, 1);
      check_eq("to_err2_hready", b_hready, 1);
      cyc();
      check_eq("to_idle_hresp", b_hresp, 0);
      c_wait = 0;
      a_irq_cnt = 0;
      for (int k = 0; k < 290; k++) begin
         if (c_penable && (c_psel == 16'h0002) && !c_hready) c_wait++;
         if (a_irq) a_irq_cnt++;
         cyc();
      end
      check_eq("nto_still_waiting", c_wait, 290);
      check_eq("to256_irq_count", a_irq_cnt, 1);
      PREADY = 1'b1; PRDATA = 32'hCAFE_F00D;
      cyc();
      check_eq("nto_done_hready", c_hready, 1);
      check_eq("nto_done_hrdata", c_hrdata, 32'hCAFE_F00D);
      check_eq("nto_done_hresp", c_hresp, 0);
      check_eq("nto_done_psel", c_psel, 0);
      idle_cycles(3);

      // back-to-back reads, second issued in the completion cycle
      PRDATA = 32'h1111_0000;
      exp_q.push_back(32'h1111_0000);
      addr_phase(32'h0000_0000, 1'b0);
      check_eq("b2b_setup1_psel", a_psel, 16'h0001);
      cyc();
      cyc();
      check_eq("b2b_done1_hready", a_hready, 1);
      check_eq("b2b_done1_hrdata", a_hrdata, exp_q.pop_front());
      PRDATA = 32'h2222_1111;
      exp_q.push_back(32'h2222_1111);
      addr_phase(32'h0000_0100, 1'b0);
      check_eq("b2b_setup2_psel", a_psel, 16'h0002);
      check_eq("b2b_setup2_penable", a_penable, 0);
      cyc();
      cyc();
      check_eq("b2b_done2_hready", a_hready, 1);
      check_eq("b2b_done2_hrdata", a_hrdata, exp_q.pop_front());
      idle_cycles(3);

      // asynchronous reset in the middle of ACCESS
      PREADY = 1'b0;
      addr_phase(32'h0000_0400, 1'b0);
      cyc();
      check_eq("rst_mid_psel_before", a_psel, 16'h0010);
      check_eq("rst_mid_penable_before", a_penable, 1);
      #2 HRESET = 1'b1;
      #1;
      check_eq("rst_mid_psel", a_psel, 0);
      check_eq("rst_mid_penable", a_penable, 0);
      check_eq("rst_mid_hready", a_hready, 1);
      cyc();
      HRESET = 1'b0;
      PREADY = 1'b1;
      cyc();
      check_eq("rst_after_hready", a_hready, 1);
      check_eq("rst_after_psel", a_psel, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
